kbd_display_ctrl: RTL

- Sequences the PS/2 keyboard display path.
- Pops scan-code bytes from the PS/2 receiver FIFO and decodes make, break and prefix bytes.
- Tracks the currently held key and maintains the key-press counter.
- Drives the seven-segment display block: `scan_code` feeds the low digits and the ASCII ROM address, `count` feeds the high digits, and `blank` turns the display off when no key is held.

---
 rtl/kbd_display_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/kbd_display_ctrl.sv
// PS/2 scan-code sequencer: pops FIFO bytes, tracks the held key and press count.
// Define KBD_EXT_KEY_EN to make E0-prefixed keys distinct from their plain codes.
module kbd_display_ctrl #(
    parameter int BCD_COUNT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic [7:0] data,
    output logic       nextdata_n,
    output logic [7:0] scan_code,
    output logic       ext,
    output logic [7:0] count,
    output logic       key_active,
    output logic       blank
);

    typedef enum logic {IDLE, POP} state_t;

    state_t     state, state_nx;
    logic       brk_pend, brk_pend_nx;
    logic       ext_pend, ext_pend_nx;
    logic       nextdata_n_nx;
    logic [7:0] scan_code_nx;
    logic       ext_nx;
    logic [7:0] count_nx;
    logic [7:0] count_inc;
    logic       key_active_nx;
    logic       same_key;

    always_comb begin
        count_inc = count + 8'd1;
        if (BCD_COUNT != 0) begin
            if (count[3:0] == 4'd9) begin
                count_inc[3:0] = 4'd0;
                count_inc[7:4] = (count[7:4] == 4'd9) ? 4'd0 : count[7:4] + 4'd1;
            end else begin
                count_inc = {count[7:4], count[3:0] + 4'd1};
            end
        end
    end

    assign same_key = (ext_pend == ext) && (data == scan_code);

    always_comb begin
        state_nx      = state;
        nextdata_n_nx = 1'b1;
        brk_pend_nx   = brk_pend;
        ext_pend_nx   = ext_pend;
        scan_code_nx  = scan_code;
        ext_nx        = ext;
        count_nx      = count;
        key_active_nx = key_active;
        unique case (state)
            IDLE: begin
                if (ready) begin
                    state_nx      = POP;
                    nextdata_n_nx = 1'b0;
                    if (data == 8'hF0) begin
                        brk_pend_nx = 1'b1;
                    end else if (data == 8'hE0) begin
`ifdef KBD_EXT_KEY_EN
                        ext_pend_nx = 1'b1;
`else
                        ext_pend_nx = 1'b0;
`endif
                    end else begin
                        if (!brk_pend) begin
                            // A repeat of the held key is typematic, not a new press
                            if (!(key_active && same_key)) begin
                                scan_code_nx  = data;
                                ext_nx        = ext_pend;
                                key_active_nx = 1'b1;
                                count_nx      = count_inc;
                            end
                        end else if (same_key) begin
                            key_active_nx = 1'b0;
                        end
                        brk_pend_nx = 1'b0;
                        ext_pend_nx = 1'b0;
                    end
                end
            end
            POP: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            nextdata_n <= 1'b1;
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
            scan_code  <= 8'h00;
            ext        <= 1'b0;
            count      <= 8'h00;
            key_active <= 1'b0;
            blank      <= 1'b1;
        end else begin
            state      <= state_nx;
            nextdata_n <= nextdata_n_nx;
            brk_pend   <= brk_pend_nx;
            ext_pend   <= ext_pend_nx;
            scan_code  <= scan_code_nx;
            ext        <= ext_nx;
            count      <= count_nx;
            key_active <= key_active_nx;
            blank      <= ~key_active_nx;
        end
    end

endmodule
